tdm_demux_4to1: RTL and testbench

- Receive-side counterpart of the 4-to-1 channel mux: takes one time-multiplexed data lane plus a frame-sync marker and distributes four consecutive slots into four parallel channel registers.
- Frame = 4 accepted beats, slot 0 first (slot 0 marked by fsync).
- Channel outputs update atomically once per complete frame; a one-cycle strobe flags each update.
- Sits between the serialized board-level lane (switch/pin inputs) and parallel consumer logic (LEDs, downstream datapath).

---
 rtl/tdm_demux_4to1.sv | 123 ++++++++++++
 tb/tb_tdm_demux_4to1.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux_4to1.sv
// Receive-side TDM demux: collects four slots of a framed lane into four channel registers.
// Optional mid-frame idle timeout enabled by defining TDM_DEMUX_TIMEOUT_EN.
module tdm_demux_4to1 #(
  parameter int WIDTH   = 1,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   d,
  input  logic               in_valid,
  input  logic               fsync,
  output logic [4*WIDTH-1:0] y,
  output logic [1:0]         s,
  output logic               frame_valid,
  output logic               err
);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  state_t             state_r;
  logic [1:0]         slot_r;
  logic [WIDTH-1:0]   sh0_r;
  logic [WIDTH-1:0]   sh1_r;
  logic [WIDTH-1:0]   sh2_r;
  logic [4*WIDTH-1:0] y_r;
  logic               fv_r;
  logic               err_r;
`ifdef TDM_DEMUX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]      idle_cnt_r;
`endif

  // Frame FSM: slot capture into shadows, atomic channel update and strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      slot_r     <= 2'd0;
      sh0_r      <= '0;
      sh1_r      <= '0;
      sh2_r      <= '0;
      y_r        <= '0;
      fv_r       <= 1'b0;
      err_r      <= 1'b0;
`ifdef TDM_DEMUX_TIMEOUT_EN
      idle_cnt_r <= '0;
`endif
    end else begin
      fv_r  <= 1'b0;
      err_r <= 1'b0;
      case (state_r)
        IDLE: begin
`ifdef TDM_DEMUX_TIMEOUT_EN
          idle_cnt_r <= '0;
`endif
          if (in_valid && fsync) begin
            sh0_r   <= d;
            slot_r  <= 2'd1;
            state_r <= RUN;
          end else begin
            slot_r  <= 2'd0;
          end
        end
        RUN: begin
          if (in_valid) begin
`ifdef TDM_DEMUX_TIMEOUT_EN
            idle_cnt_r <= '0;
`endif
            // An early sync drops the partial frame and restarts at slot 0.
            if (fsync) begin
              err_r  <= 1'b1;
              sh0_r  <= d;
              slot_r <= 2'd1;
            end else begin
              case (slot_r)
                2'd1: begin
                  sh1_r  <= d;
                  slot_r <= 2'd2;
                end
                2'd2: begin
                  sh2_r  <= d;
                  slot_r <= 2'd3;
                end
                default: begin
                  y_r     <= {d, sh2_r, sh1_r, sh0_r};
                  fv_r    <= 1'b1;
                  slot_r  <= 2'd0;
                  state_r <= IDLE;
                end
              endcase
            end
          end else begin
`ifdef TDM_DEMUX_TIMEOUT_EN
            if (idle_cnt_r == CW'(TIMEOUT - 1)) begin
              err_r      <= 1'b1;
              slot_r     <= 2'd0;
              idle_cnt_r <= '0;
              state_r    <= IDLE;
            end else begin
              idle_cnt_r <= idle_cnt_r + CW'(1);
            end
`else
            slot_r <= slot_r;
`endif
          end
        end
        default: begin
          state_r <= IDLE;
          slot_r  <= 2'd0;
        end
      endcase
    end
  end

  assign y           = y_r;
  assign s           = slot_r;
  assign frame_valid = fv_r;
  assign err         = err_r;

endmodule

// File: tb/tb_tdm_demux_4to1.sv
// Directed bench for tdm_demux_4to1: WIDTH=1 and WIDTH=4 instances, hand-computed frames.
// Timeout section follows TDM_DEMUX_TIMEOUT_EN.
module tb_tdm_demux_4to1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [0:0]  d1 = 1'b0;
  logic        v1 = 1'b0, f1 = 1'b0;
  logic [3:0]  y1;
  logic [1:0]  s1;
  logic        fv1, err1;
  logic [3:0]  d4 = 4'h0;
  logic        v4 = 1'b0, f4 = 1'b0;
  logic [15:0] y4;
  logic [1:0]  s4;
  logic        fv4, err4;

  int vec_cnt = 0;
  int miss_cnt = 0;
  int fv_pulses = 0;
  int err_pulses = 0;
  int both_hi = 0;

  always #5 clk = ~clk;

  tdm_demux_4to1 #(.WIDTH(1), .TIMEOUT(15)) dut1 (
    .clk(clk), .rst_n(rst_n), .d(d1), .in_valid(v1), .fsync(f1),
    .y(y1), .s(s1), .frame_valid(fv1), .err(err1));

  tdm_demux_4to1 #(.WIDTH(4), .TIMEOUT(15)) dut4 (
    .clk(clk), .rst_n(rst_n), .d(d4), .in_valid(v4), .fsync(f4),
    .y(y4), .s(s4), .frame_valid(fv4), .err(err4));

  // Pulse bookkeeping on the WIDTH=4 instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (fv4) fv_pulses++;
    if (err4) err_pulses++;
    if (fv4 && err4) both_hi++;
  end

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic beat4(input logic [3:0] data, input logic fs, input logic vld);
    d4 = data; f4 = fs; v4 = vld;
    @(posedge clk); #1;
  endtask

  task automatic beat1(input logic data, input logic fs);
    d1 = data; f1 = fs; v1 = 1'b1;
    @(posedge clk); #1;
  endtask

  int fv_base, err_base;

  initial begin
    // Reset held with random activity on the inputs
    for (int i = 0; i < 4; i++) begin
      d4 = 4'($urandom); v4 = 1'($urandom); f4 = 1'($urandom);
      d1 = 1'($urandom); v1 = 1'($urandom); f1 = 1'($urandom);
      @(posedge clk); #1;
    end
    check_val("rst_y4", y4, 16'h0000);
    check_val("rst_s4", {14'd0, s4}, 16'd0);
    check_val("rst_fv_err4", {14'd0, fv4, err4}, 16'd0);
    check_val("rst_y1", {12'd0, y1}, 16'h0);
    v4 = 1'b0; f4 = 1'b0; v1 = 1'b0; f1 = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check_val("idle_y4", y4, 16'h0000);
    check_val("idle_s4_fv_err", {12'd0, s4, fv4, err4}, 16'd0);

    // Basic WIDTH=1 frame: 1,0,1,1
    beat1(1'b1, 1'b1); check_val("b1_s_a", {14'd0, s1}, 16'd1);
    beat1(1'b0, 1'b0); check_val("b1_s_b", {14'd0, s1}, 16'd2);
    beat1(1'b1, 1'b0); check_val("b1_s_c", {14'd0, s1}, 16'd3);
    check_val("b1_fv_early", {15'd0, fv1}, 16'd0);
    beat1(1'b1, 1'b0); v1 = 1'b0;
    check_val("b1_s_d", {14'd0, s1}, 16'd0);
    check_val("b1_y", {12'd0, y1}, 16'h000D);
    check_val("b1_fv", {15'd0, fv1}, 16'd1);
    @(posedge clk); #1;
    check_val("b1_fv_one", {15'd0, fv1}, 16'd0);
    check_val("b1_y_hold", {12'd0, y1}, 16'h000D);

    // Stall inside frame A, then frame B back-to-back
    fv_base = fv_pulses; err_base = err_pulses;
    beat4(4'hA, 1'b1, 1'b1);
    beat4(4'hB, 1'b0, 1'b1);
    beat4(4'h0, 1'b0, 1'b0);
    beat4(4'h0, 1'b0, 1'b0);
    check_val("stall_s", {14'd0, s4}, 16'd2);
    check_val("stall_y", y4, 16'h0000);
    beat4(4'hC, 1'b0, 1'b1);
    beat4(4'hD, 1'b0, 1'b1);
    check_val("frmA_y", y4, 16'hDCBA);
    check_val("frmA_fv", {15'd0, fv4}, 16'd1);
    beat4(4'h1, 1'b1, 1'b1);
    check_val("frmB_s0", {14'd0, s4}, 16'd1);
    check_val("frmB_fv_low", {15'd0, fv4}, 16'd0);
    beat4(4'h2, 1'b0, 1'b1);
    beat4(4'h3, 1'b0, 1'b1);
    check_val("frmB_y_hold", y4, 16'hDCBA);
    beat4(4'h4, 1'b0, 1'b1);
    check_val("frmB_y", y4, 16'h4321);
    check_val("frmB_fv", {15'd0, fv4}, 16'd1);
    beat4(4'h0, 1'b0, 1'b0);
    check_val("ab_fv_pulses", 16'(fv_pulses - fv_base), 16'd2);
    check_val("ab_err_none", 16'(err_pulses - err_base), 16'd0);

    // Early sync restarts the frame
    err_base = err_pulses;
    beat4(4'h5, 1'b1, 1'b1);
    beat4(4'h6, 1'b0, 1'b1);
    beat4(4'h7, 1'b1, 1'b1);
    check_val("early_err", {15'd0, err4}, 16'd1);
    check_val("early_s", {14'd0, s4}, 16'd1);
    check_val("early_y_hold", y4, 16'h4321);
    beat4(4'h8, 1'b0, 1'b1);
    check_val("early_err_one", {15'd0, err4}, 16'd0);
    beat4(4'h9, 1'b0, 1'b1);
    beat4(4'hA, 1'b0, 1'b1);
    check_val("early_y", y4, 16'hA987);
    check_val("early_fv", {15'd0, fv4}, 16'd1);
    beat4(4'h0, 1'b0, 1'b0);
    check_val("early_err_cnt", 16'(err_pulses - err_base), 16'd1);

    // Sync hunting, then reset mid-frame
    fv_base = fv_pulses;
    beat4(4'h3, 1'b0, 1'b1);
    check_val("hunt_s_a", {14'd0, s4}, 16'd0);
    beat4(4'h4, 1'b0, 1'b1);
    check_val("hunt_s_b", {14'd0, s4}, 16'd0);
    check_val("hunt_y", y4, 16'hA987);
    beat4(4'h1, 1'b1, 1'b1);
    beat4(4'h2, 1'b0, 1'b1);
    check_val("mid_s", {14'd0, s4}, 16'd2);
    v4 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_val("mid_rst_y", y4, 16'h0000);
    check_val("mid_rst_s", {14'd0, s4}, 16'd0);
    @(negedge clk); rst_n = 1'b1;
    beat4(4'h0, 1'b0, 1'b0);
    check_val("mid_rst_fv_none", 16'(fv_pulses - fv_base), 16'd0);

    // Idle timeout behaviour
    err_base = err_pulses;
    beat4(4'h1, 1'b1, 1'b1);
    beat4(4'h2, 1'b0, 1'b1);
    for (int i = 0; i < 14; i++) beat4(4'h0, 1'b0, 1'b0);
    check_val("to_pre_err", 16'(err_pulses - err_base), 16'd0);
    check_val("to_pre_s", {14'd0, s4}, 16'd2);
    beat4(4'h0, 1'b0, 1'b0);
`ifdef TDM_DEMUX_TIMEOUT_EN
    check_val("to_err", {15'd0, err4}, 16'd1);
    check_val("to_s", {14'd0, s4}, 16'd0);
    beat4(4'h0, 1'b0, 1'b0);
    check_val("to_err_one", {15'd0, err4}, 16'd0);
    beat4(4'h4, 1'b1, 1'b1);
    beat4(4'h5, 1'b0, 1'b1);
    beat4(4'h6, 1'b0, 1'b1);
    beat4(4'h7, 1'b0, 1'b1);
    check_val("to_next_y", y4, 16'h7654);
    check_val("to_next_fv", {15'd0, fv4}, 16'd1);
`else
    check_val("nto_err", {15'd0, err4}, 16'd0);
    check_val("nto_s", {14'd0, s4}, 16'd2);
    beat4(4'h3, 1'b0, 1'b1);
    beat4(4'h4, 1'b0, 1'b1);
    check_val("nto_y", y4, 16'h4321);
    check_val("nto_fv", {15'd0, fv4}, 16'd1);
`endif
    beat4(4'h0, 1'b0, 1'b0);
    check_val("fv_err_exclusive", 16'(both_hi), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
